// File: rtl/hongwai_ir_tx.sv
// Gree-style air-conditioner IR remote transmitter: one key press sends
// leader, 35-bit word, gap, 32-bit word and stop mark on a 38 kHz carrier.
module hongwai_ir_tx #(
    parameter logic [34:0] DATA35      = 35'b11111000001111100000111110000011111,
    parameter logic [31:0] DATA32      = 32'b11111000001111100000111110000011,
    parameter int          CARR_PERIOD = 1053,
    parameter int          CARR_HIGH   = 351,
    parameter int          LEAD_MARK   = 360000,
    parameter int          LEAD_SPACE  = 180000,
    parameter int          BIT_MARK    = 22400,
    parameter int          ZERO_SPACE  = 22400,
    parameter int          ONE_SPACE   = 67600,
    parameter int          GAP_SPACE   = 800000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_1,
    output logic IR_out,
    output logic led_out
);

    localparam int CNT_W = 20;
    localparam int PH_W  = 11;

    // Segment counters are loaded with length-1 so every segment lasts exactly its length.
    localparam logic [CNT_W-1:0] LEAD_MARK_LD  = CNT_W'(LEAD_MARK - 1);
    localparam logic [CNT_W-1:0] LEAD_SPACE_LD = CNT_W'(LEAD_SPACE - 1);
    localparam logic [CNT_W-1:0] BIT_MARK_LD   = CNT_W'(BIT_MARK - 1);
    localparam logic [CNT_W-1:0] ZERO_SPACE_LD = CNT_W'(ZERO_SPACE - 1);
    localparam logic [CNT_W-1:0] ONE_SPACE_LD  = CNT_W'(ONE_SPACE - 1);
    localparam logic [CNT_W-1:0] GAP_SPACE_LD  = CNT_W'(GAP_SPACE - 1);
    localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(CARR_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HIGH       = PH_W'(CARR_HIGH);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_M,
        LEAD_S,
        W1_M,
        W1_S,
        GAP_M,
        GAP_S,
        W2_M,
        W2_S,
        STOP_M
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic [5:0]        bit_idx;
    logic              key_s1;
    logic              key_s2;
    logic              key_s3;
    logic              key_edge;
    logic              is_mark;
    logic [CNT_W-1:0]  w1_space;
    logic [CNT_W-1:0]  w2_space;

    // The synchronizer is left out of reset so a key held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        key_s1 <= key_1;
        key_s2 <= key_s1;
        key_s3 <= key_s2;
    end

    always_comb begin
        key_edge  = key_s2 & ~key_s3;
        is_mark   = (state == LEAD_M) || (state == W1_M) || (state == GAP_M) ||
                    (state == W2_M)   || (state == STOP_M);
        phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
        w1_space  = DATA35[bit_idx] ? ONE_SPACE_LD : ZERO_SPACE_LD;
        w2_space  = DATA32[bit_idx[4:0]] ? ONE_SPACE_LD : ZERO_SPACE_LD;
    end

    // Every mark entry restarts the carrier at phase 0, which is always a high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= '0;
            bit_idx <= '0;
            IR_out  <= 1'b0;
            led_out <= 1'b0;
        end else if (state == IDLE) begin
            IR_out  <= 1'b0;
            led_out <= 1'b0;
            if (key_edge) begin
                state   <= LEAD_M;
                cnt     <= LEAD_MARK_LD;
                phase   <= '0;
                bit_idx <= '0;
                IR_out  <= 1'b1;
                led_out <= 1'b1;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (is_mark) begin
                phase  <= phase_nxt;
                IR_out <= (phase_nxt < PH_HIGH);
            end else begin
                IR_out <= 1'b0;
            end
        end else begin
            case (state)
                LEAD_M: begin
                    state  <= LEAD_S;
                    cnt    <= LEAD_SPACE_LD;
                    IR_out <= 1'b0;
                end
                LEAD_S: begin
                    state   <= W1_M;
                    bit_idx <= '0;
                    cnt     <= BIT_MARK_LD;
                    phase   <= '0;
                    IR_out  <= 1'b1;
                end
                W1_M: begin
                    state  <= W1_S;
                    cnt    <= w1_space;
                    IR_out <= 1'b0;
                end
                W1_S: begin
                    if (bit_idx == 6'd34) begin
                        state <= GAP_M;
                    end else begin
                        state   <= W1_M;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    cnt    <= BIT_MARK_LD;
                    phase  <= '0;
                    IR_out <= 1'b1;
                end
                GAP_M: begin
                    state  <= GAP_S;
                    cnt    <= GAP_SPACE_LD;
                    IR_out <= 1'b0;
                end
                GAP_S: begin
                    state   <= W2_M;
                    bit_idx <= '0;
                    cnt     <= BIT_MARK_LD;
                    phase   <= '0;
                    IR_out  <= 1'b1;
                end
                W2_M: begin
                    state  <= W2_S;
                    cnt    <= w2_space;
                    IR_out <= 1'b0;
                end
                W2_S: begin
                    if (bit_idx == 6'd31) begin
                        state <= STOP_M;
                    end else begin
                        state   <= W2_M;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    cnt    <= BIT_MARK_LD;
                    phase  <= '0;
                    IR_out <= 1'b1;
                end
                STOP_M: begin
                    state   <= IDLE;
                    bit_idx <= '0;
                    phase   <= '0;
                    IR_out  <= 1'b0;
                    led_out <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    IR_out  <= 1'b0;
                    led_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hongwai_ir_tx.sv
// Bench for hongwai_ir_tx with shortened timing parameters so whole frames
// can be captured, decoded and compared against a waveform built here.
`timescale 1ns/1ps
module tb_hongwai_ir_tx;

    localparam logic [34:0] D35 = 35'b11111000001111100000111110000011111;
    localparam logic [31:0] D32 = 32'b11111000001111100000111110000011;
    localparam int P   = 6;
    localparam int H   = 2;
    localparam int LM  = 24;
    localparam int LS  = 12;
    localparam int BM  = 8;
    localparam int ZS  = 6;
    localparam int OS  = 14;
    localparam int GS  = 40;
    // 36 leader + 650 word1 + 48 gap + 584 word2 + 8 stop
    localparam int FRAME_LEN = 1326;
    localparam int LOW_RUN   = P - H;

    logic clk = 1'b0;
    logic rst;
    logic key_1;
    logic IR_out;
    logic led_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic frame_q[$];
    logic exp_q[$];

    typedef struct {
        logic    rst;
        logic    key;
        int      cycles;
        logic    exp_ir;
        logic    exp_led;
        realtime at_ns;
        string   name;
    } vec_t;

    vec_t vecs[9];

    hongwai_ir_tx #(
        .DATA35(D35), .DATA32(D32), .CARR_PERIOD(P), .CARR_HIGH(H),
        .LEAD_MARK(LM), .LEAD_SPACE(LS), .BIT_MARK(BM), .ZERO_SPACE(ZS),
        .ONE_SPACE(OS), .GAP_SPACE(GS)
    ) dut (
        .clk(clk), .rst(rst), .key_1(key_1), .IR_out(IR_out), .led_out(led_out)
    );

    always #12.5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int bad = 0;
        if (v.at_ns > $realtime) #(v.at_ns - $realtime);
        rst   = v.rst;
        key_1 = v.key;
        for (int c = 0; c < v.cycles; c++) begin
            @(posedge clk);
            #1;
            if (IR_out !== v.exp_ir || led_out !== v.exp_led) bad++;
        end
        checkOutput(v.name, bad, 0);
    endtask

    task automatic add_mark(input int len);
        for (int k = 0; k < len; k++) exp_q.push_back((k % P) < H);
    endtask

    task automatic add_space(input int len);
        for (int k = 0; k < len; k++) exp_q.push_back(1'b0);
    endtask

    task automatic press_and_latency(input string tag);
        int lat = 0;
        @(negedge clk);
        key_1 = 1'b1;
        while (lat < 10 && led_out !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " start latency"}, lat, 3);
    endtask

    task automatic capture_frame();
        int n = 0;
        frame_q.delete();
        @(negedge clk);
        while (led_out === 1'b1 && n < 4000) begin
            frame_q.push_back(IR_out);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic analyze_frame(input string tag);
        int len = frame_q.size();
        int mism = 0;
        int lead_bad = 0;
        int bad_code = 0;
        int last_end = 0;
        int spaces[$];
        logic [34:0] w1;
        logic [31:0] w2;
        int i = 0;
        checkOutput({tag, " frame length"}, len, FRAME_LEN);
        for (int k = 0; k < len && k < exp_q.size(); k++)
            if (frame_q[k] !== exp_q[k]) mism++;
        checkOutput({tag, " waveform mismatches"}, mism, 0);
        for (int k = 0; k < LM && k < len; k++)
            if (frame_q[k] !== ((k % P) < H)) lead_bad++;
        checkOutput({tag, " leader carrier"}, lead_bad, 0);
        // Low runs longer than the carrier's own low stretch are spaces.
        while (i < len) begin
            if (frame_q[i] === 1'b0) begin
                int j = i;
                while (j < len && frame_q[j] === 1'b0) j++;
                if (j - i > LOW_RUN) begin
                    spaces.push_back(j - i);
                    last_end = j;
                end
                i = j;
            end else begin
                i++;
            end
        end
        checkOutput({tag, " space count"}, spaces.size(), 69);
        if (spaces.size() == 69) begin
            // Leader mark is a whole number of carrier periods, so its low tail joins the space.
            checkOutput({tag, " leader space"}, spaces[0], LS + LOW_RUN);
            for (int b = 0; b < 35; b++) begin
                w1[b] = (spaces[1 + b] == OS);
                if (spaces[1 + b] != OS && spaces[1 + b] != ZS) bad_code++;
            end
            for (int b = 0; b < 32; b++) begin
                w2[b] = (spaces[37 + b] == OS);
                if (spaces[37 + b] != OS && spaces[37 + b] != ZS) bad_code++;
            end
            checkOutput({tag, " word1 decode"}, w1, D35);
            checkOutput({tag, " gap space"}, spaces[36], GS);
            checkOutput({tag, " word2 decode"}, w2, D32);
            checkOutput({tag, " bad space codes"}, bad_code, 0);
            checkOutput({tag, " stop mark"}, len - last_end, BM);
        end
    endtask

    initial begin
        int busy;

        rst   = 1'b1;
        key_1 = 1'b0;

        add_mark(LM);
        add_space(LS);
        for (int b = 0; b < 35; b++) begin
            add_mark(BM);
            add_space(D35[b] ? OS : ZS);
        end
        add_mark(BM);
        add_space(GS);
        for (int b = 0; b < 32; b++) begin
            add_mark(BM);
            add_space(D32[b] ? OS : ZS);
        end
        add_mark(BM);

        vecs[0] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 0.0,   "reset"};
        vecs[1] = '{1'b0, 1'b0, 4,  1'b0, 1'b0, 0.0,   "idle no key"};
        vecs[2] = '{1'b0, 1'b1, 2,  1'b0, 1'b0, 130.0, "sync delay"};
        vecs[3] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 0.0,   "third clk start"};
        vecs[4] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 0.0,   "carrier phase 1"};
        vecs[5] = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 0.0,   "carrier phase 2"};
        vecs[6] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 0.0,   "reset abort"};
        vecs[7] = '{1'b0, 1'b1, 30, 1'b0, 1'b0, 0.0,   "held key after reset"};
        vecs[8] = '{1'b0, 1'b0, 3,  1'b0, 1'b0, 0.0,   "release key"};
        for (int v = 0; v < 9; v++) applyStimulus(vecs[v]);

        // Frame A with the key held for two frame lengths, then frame B after re-press.
        press_and_latency("frameA");
        capture_frame();
        analyze_frame("frameA");
        busy = 0;
        repeat (FRAME_LEN + 20) begin
            @(negedge clk);
            if (led_out !== 1'b0 || IR_out !== 1'b0) busy++;
        end
        checkOutput("held key no retrigger", busy, 0);
        key_1 = 1'b0;
        repeat (3) @(negedge clk);
        press_and_latency("frameB");
        key_1 = 1'b0;
        capture_frame();
        analyze_frame("frameB");

        // Frame C with a second press landing in the gap space.
        repeat (5) @(negedge clk);
        press_and_latency("frameC");
        key_1 = 1'b0;
        fork
            capture_frame();
            begin
                repeat (700) @(negedge clk);
                key_1 = 1'b1;
                repeat (4) @(negedge clk);
                key_1 = 1'b0;
            end
        join
        analyze_frame("frameC");
        busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (led_out !== 1'b0 || IR_out !== 1'b0) busy++;
        end
        checkOutput("gap press ignored", busy, 0);

        // Frame D aborted by reset in the middle of word1.
        press_and_latency("frameD");
        key_1 = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("frameD busy before reset", led_out, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-frame reset IR_out", IR_out, 1'b0);
        checkOutput("mid-frame reset led_out", led_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        busy = 0;
        repeat (300) begin
            @(negedge clk);
            if (led_out !== 1'b0 || IR_out !== 1'b0) busy++;
        end
        checkOutput("quiet after reset", busy, 0);
        press_and_latency("after reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
